// File: rtl/amm_burst_responder.sv
// Avalon-MM burst slave: byte-masked burst writes into on-chip storage and
// fixed-latency pipelined burst reads fed from a small outstanding-command FIFO.
module amm_burst_responder #(
  parameter int AMM_DATA_W     = 128,
  parameter int AMM_ADDR_W     = 12,
  parameter int AMM_BURST_W    = 11,
  parameter int MEM_DEPTH_W    = 8,
  parameter int READ_LATENCY   = 4,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int BYTE_PER_WORD  = AMM_DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [AMM_ADDR_W-1:0]    address_i,
  input  logic                     read_i,
  input  logic                     write_i,
  input  logic [AMM_DATA_W-1:0]    writedata_i,
  input  logic [BYTE_PER_WORD-1:0] byteenable_i,
  input  logic [AMM_BURST_W-1:0]   burstcount_i,
  output logic                     waitrequest_o,
  output logic [AMM_DATA_W-1:0]    readdata_o,
  output logic                     readdatavalid_o,
  input  logic                     stall_i,
  output logic                     protocol_err_o
);
  localparam int PTR_W     = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int MEM_WORDS = 1 << MEM_DEPTH_W;
  localparam logic [PTR_W:0]       FIFO_FULL = (PTR_W+1)'(CMD_FIFO_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(CMD_FIFO_DEPTH - 1);
  localparam logic [3:0]           LAT_LOAD  = 4'(READ_LATENCY - 2);
  localparam logic [AMM_BURST_W-1:0] ONE_BEAT = AMM_BURST_W'(1);

  typedef enum logic {IDLE, WR_BURST} state_t;
  typedef struct packed {
    logic [MEM_DEPTH_W-1:0] addr;
    logic [AMM_BURST_W-1:0] len;
  } cmd_t;

  state_t                 state, state_nxt;
  logic [MEM_DEPTH_W-1:0] wr_addr;
  logic [AMM_BURST_W-1:0] wr_left;

  logic [AMM_DATA_W-1:0]  mem [MEM_WORDS];
  cmd_t                   fifo [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]       fifo_wp, fifo_rp;
  logic [PTR_W:0]         fifo_cnt;

  logic                   rd_busy;
  logic [3:0]             lat_cnt;
  logic [AMM_BURST_W-1:0] rd_left;
  logic [MEM_DEPTH_W-1:0] rd_addr;

  logic fifo_empty, fifo_full, in_idle, burst_zero, accept;
  logic rd_cmd, wr_first, wr_beat, wr_en, err_hit, pop;
  logic [MEM_DEPTH_W-1:0] wr_word;
  logic unused_addr;

  assign unused_addr = ^address_i;
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == FIFO_FULL);
  assign in_idle     = (state == IDLE);
  assign burst_zero  = (burstcount_i == '0);

  // Writes wait for all queued reads to drain, so reads always see pre-write data.
  assign waitrequest_o = stall_i | (read_i & fifo_full)
                       | (write_i & in_idle & (!fifo_empty | rd_busy));
  assign accept = (read_i | write_i) & !waitrequest_o;

  assign rd_cmd   = accept & read_i & !write_i & in_idle & !burst_zero;
  assign wr_first = accept & write_i & !read_i & in_idle & !burst_zero;
  assign wr_beat  = accept & write_i & !read_i & !in_idle;
  assign wr_en    = wr_first | wr_beat;
  assign err_hit  = accept & ((read_i & write_i) | (in_idle & burst_zero) | (read_i & !in_idle));
  assign wr_word  = in_idle ? address_i[MEM_DEPTH_W-1:0] : wr_addr;
  assign pop      = !rd_busy & !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (wr_first && burstcount_i != ONE_BEAT) state_nxt = WR_BURST;
      WR_BURST: if (wr_beat && wr_left == ONE_BEAT)       state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_addr <= '0;
      wr_left <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_word + MEM_DEPTH_W'(1);
      wr_left <= in_idle ? burstcount_i - ONE_BEAT : wr_left - ONE_BEAT;
    end

  // Storage and FIFO payload carry no reset; only the pointers do.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int b = 0; b < BYTE_PER_WORD; b++)
        if (byteenable_i[b]) mem[wr_word][b*8 +: 8] <= writedata_i[b*8 +: 8];
    if (rd_cmd) fifo[fifo_wp] <= '{addr: address_i[MEM_DEPTH_W-1:0], len: burstcount_i};
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rd_cmd) fifo_wp <= (fifo_wp == PTR_LAST) ? '0 : fifo_wp + PTR_W'(1);
      if (pop)    fifo_rp <= (fifo_rp == PTR_LAST) ? '0 : fifo_rp + PTR_W'(1);
      case ({rd_cmd, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end

  // Pop cycle loads the latency counter; beats then stream back to back.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      rd_busy         <= 1'b0;
      lat_cnt         <= '0;
      rd_left         <= '0;
      rd_addr         <= '0;
      readdata_o      <= '0;
      readdatavalid_o <= 1'b0;
    end else begin
      readdatavalid_o <= 1'b0;
      if (pop) begin
        rd_busy <= 1'b1;
        lat_cnt <= LAT_LOAD;
        rd_left <= fifo[fifo_rp].len;
        rd_addr <= fifo[fifo_rp].addr;
      end else if (rd_busy) begin
        if (lat_cnt != '0) begin
          lat_cnt <= lat_cnt - 4'd1;
        end else begin
          readdatavalid_o <= 1'b1;
          readdata_o      <= mem[rd_addr];
          rd_addr         <= rd_addr + MEM_DEPTH_W'(1);
          rd_left         <= rd_left - ONE_BEAT;
          if (rd_left == ONE_BEAT) rd_busy <= 1'b0;
        end
      end
    end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)       protocol_err_o <= 1'b0;
    else if (err_hit) protocol_err_o <= 1'b1;

endmodule
